// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter.
//   ROB_WIDTH_BIT : ROB tag width (32-entry ROB)
//   CDB_NUM_REQ   : default number of CDB producers
//   CDB_REQ_RS    : requester index of the RS execute stage
//   CDB_REQ_LSB   : requester index of the load/store buffer
//   idx_w()       : index width for an n-entry vector (at least 1 bit)
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH_BIT = 5;
  localparam int CDB_NUM_REQ   = 2;
  localparam int CDB_REQ_RS    = 0;
  localparam int CDB_REQ_LSB   = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin one-hot picker. The search starts at ptr_i and
// walks upward modulo N; the first set request wins.
//   req_i   : request vector
//   ptr_i   : search start index (must be < N)
//   grant_o : one-hot grant, zero when no request is set
//   idx_o   : index of the granted request (0 when none)
//   any_o   : at least one request was granted
module cdb_arbiter_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    logic [IDX_W:0] pos;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      // one extra bit so the wrap compare cannot overflow
      pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
      if (!any_o && req_i[pos[IDX_W-1:0]]) begin
        any_o                    = 1'b1;
        grant_o[pos[IDX_W-1:0]]  = 1'b1;
        idx_o                    = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Each producer owns a one-deep holding slot; a
// round-robin pick broadcasts one {rob_id, value} per cycle on registered
// CDB outputs. req_ready is combinational so a slot being drained this
// cycle can be refilled on the same edge (1 result/cycle per producer).
//   clk_in, rst_n_in : clock, async active-low reset
//   rdy_in           : global pause when low (everything frozen)
//   clear_in         : synchronous flush of all slots
//   req_valid/rob_id/value : packed per-requester results
//   req_ready        : slot can accept this cycle
//   cdb_valid/rob_id/value : registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = CDB_NUM_REQ,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = ROB_WIDTH_BIT
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         clear_in,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ROB_ID_W-1:0]  req_rob_id,
  input  logic [NUM_REQ*DATA_W-1:0]    req_value,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         cdb_valid,
  output logic [ROB_ID_W-1:0]          cdb_rob_id,
  output logic [DATA_W-1:0]            cdb_value
);

  localparam int PTR_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]                slot_v_q,   slot_v_d;
  logic [NUM_REQ-1:0][ROB_ID_W-1:0]  slot_tag_q, slot_tag_d;
  logic [NUM_REQ-1:0][DATA_W-1:0]    slot_val_q, slot_val_d;
  logic [PTR_W-1:0]                  ptr_q,      ptr_d;
  logic                              cdb_v_q,    cdb_v_d;
  logic [ROB_ID_W-1:0]               cdb_tag_q,  cdb_tag_d;
  logic [DATA_W-1:0]                 cdb_val_q,  cdb_val_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;

  cdb_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_pick (
    .req_i   (slot_v_q),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign req_ready = {NUM_REQ{rdy_in && !clear_in}} & (~slot_v_q | grant);

  always_comb begin
    slot_v_d   = slot_v_q;
    slot_tag_d = slot_tag_q;
    slot_val_d = slot_val_q;
    ptr_d      = ptr_q;
    cdb_v_d    = cdb_v_q;
    cdb_tag_d  = cdb_tag_q;
    cdb_val_d  = cdb_val_q;
    if (rdy_in) begin
      if (clear_in) begin
        // flush wins over any grant; tag/value regs and pointer hold
        slot_v_d = '0;
        cdb_v_d  = 1'b0;
      end else begin
        cdb_v_d = grant_any;
        if (grant_any) begin
          cdb_tag_d = slot_tag_q[grant_idx];
          cdb_val_d = slot_val_q[grant_idx];
          ptr_d     = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant[i]) slot_v_d[i] = 1'b0;
          if (req_valid[i] && req_ready[i]) begin
            slot_v_d[i]   = 1'b1;
            slot_tag_d[i] = req_rob_id[i*ROB_ID_W +: ROB_ID_W];
            slot_val_d[i] = req_value[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot_v_q   <= '0;
      slot_tag_q <= '0;
      slot_val_q <= '0;
      ptr_q      <= '0;
      cdb_v_q    <= 1'b0;
      cdb_tag_q  <= '0;
      cdb_val_q  <= '0;
    end else begin
      slot_v_q   <= slot_v_d;
      slot_tag_q <= slot_tag_d;
      slot_val_q <= slot_val_d;
      ptr_q      <= ptr_d;
      cdb_v_q    <= cdb_v_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_val_q  <= cdb_val_d;
    end
  end

  assign cdb_valid  = cdb_v_q;
  assign cdb_rob_id = cdb_tag_q;
  assign cdb_value  = cdb_val_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int TW = ROB_WIDTH_BIT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rdy;
  logic             clr;
  logic [N-1:0]     vld;
  logic [N*TW-1:0]  tags;
  logic [N*DW-1:0]  vals;
  logic [N-1:0]     ready;
  logic             cdb_v;
  logic [TW-1:0]    cdb_tag;
  logic [DW-1:0]    cdb_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ROB_ID_W(TW)) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .rdy_in     (rdy),
    .clear_in   (clr),
    .req_valid  (vld),
    .req_rob_id (tags),
    .req_value  (vals),
    .req_ready  (ready),
    .cdb_valid  (cdb_v),
    .cdb_rob_id (cdb_tag),
    .cdb_value  (cdb_val)
  );

  typedef struct {
    logic          rdy;
    logic          clr;
    logic [1:0]    vld;
    logic [TW-1:0] t0;
    logic [DW-1:0] v0;
    logic [TW-1:0] t1;
    logic [DW-1:0] v1;
    logic [1:0]    e_rdy;
    logic          e_cv;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_val;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic c, logic [1:0] v,
                              int t0, int v0, int t1, int v1,
                              logic [1:0] er, logic ecv, int et, int ev);
    vec_t x;
    x.rdy = r;  x.clr = c;  x.vld = v;
    x.t0 = TW'(t0); x.v0 = DW'(v0); x.t1 = TW'(t1); x.v1 = DW'(v1);
    x.e_rdy = er; x.e_cv = ecv; x.e_tag = TW'(et); x.e_val = DW'(ev);
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    rdy  = x.rdy;
    clr  = x.clr;
    vld  = x.vld;
    tags[CDB_REQ_RS*TW  +: TW] = x.t0;
    tags[CDB_REQ_LSB*TW +: TW] = x.t1;
    vals[CDB_REQ_RS*DW  +: DW] = x.v0;
    vals[CDB_REQ_LSB*DW +: DW] = x.v1;
  endtask

  initial begin
    // idle / single RS request / single LSB request
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 0,0,0));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 0,0,0));
    vecs.push_back(mk(1,0,2'b01, 3,'h2A,  0,0,      2'b11, 0,0,0));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 0,0,0));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 1,3,'h2A));
    vecs.push_back(mk(1,0,2'b10, 0,0,     7,'h77,   2'b11, 0,3,'h2A));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 0,3,'h2A));
    // contention from ptr=0: CDB order 1,9,2,10,3,11
    vecs.push_back(mk(1,0,2'b11, 1,'h101, 9,'h109,  2'b11, 1,7,'h77));
    vecs.push_back(mk(1,0,2'b11, 2,'h102, 10,'h10A, 2'b01, 0,7,'h77));
    vecs.push_back(mk(1,0,2'b11, 3,'h103, 10,'h10A, 2'b10, 1,1,'h101));
    vecs.push_back(mk(1,0,2'b11, 3,'h103, 11,'h10B, 2'b01, 1,9,'h109));
    vecs.push_back(mk(1,0,2'b10, 0,0,     11,'h10B, 2'b10, 1,2,'h102));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b01, 1,10,'h10A));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 1,3,'h103));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 1,11,'h10B));
    // back-pressure: RS slot full while LSB wins
    vecs.push_back(mk(1,0,2'b01, 4,'h44,  0,0,      2'b11, 0,11,'h10B));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 0,11,'h10B));
    vecs.push_back(mk(1,0,2'b11, 6,'hDEAD,5,'h55,   2'b11, 1,4,'h44));
    vecs.push_back(mk(1,0,2'b01, 8,'h88,  0,0,      2'b10, 0,4,'h44));
    vecs.push_back(mk(1,0,2'b01, 8,'h88,  0,0,      2'b11, 1,5,'h55));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 1,6,'hDEAD));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 1,8,'h88));
    // pause with both slots full (clear ignored while paused)
    vecs.push_back(mk(1,0,2'b11, 12,'h0C0C,13,'h0D0D,2'b11, 0,8,'h88));
    vecs.push_back(mk(0,0,2'b11, 14,'hE,  15,'hF,   2'b00, 0,8,'h88));
    vecs.push_back(mk(0,1,2'b11, 14,'hE,  15,'hF,   2'b00, 0,8,'h88));
    vecs.push_back(mk(0,0,2'b00, 0,0,     0,0,      2'b00, 0,8,'h88));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b10, 0,8,'h88));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 1,13,'h0D0D));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 1,12,'h0C0C));
    // flush with both slots full
    vecs.push_back(mk(1,0,2'b11, 20,'h2020,21,'h2121,2'b11, 0,12,'h0C0C));
    vecs.push_back(mk(1,1,2'b11, 22,'h2222,23,'h2323,2'b00, 0,12,'h0C0C));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 0,12,'h0C0C));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 0,12,'h0C0C));
    vecs.push_back(mk(1,0,2'b00, 0,0,     0,0,      2'b11, 0,12,'h0C0C));

    rst_n = 1'b0;
    drive(mk(1,0,2'b00, 0,0,0,0, 2'b00, 0,0,0));
    @(posedge clk);
    @(negedge clk);
    check("reset cdb_valid",  32'(cdb_v),   32'd0);
    check("reset cdb_rob_id", 32'(cdb_tag), 32'd0);
    check("reset cdb_value",  cdb_val,      32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d req_ready", i),  32'(ready),   32'(vecs[i].e_rdy));
      check($sformatf("v%0d cdb_valid", i),  32'(cdb_v),   32'(vecs[i].e_cv));
      check($sformatf("v%0d cdb_rob_id", i), 32'(cdb_tag), 32'(vecs[i].e_tag));
      check($sformatf("v%0d cdb_value", i),  cdb_val,      vecs[i].e_val);
      @(posedge clk);
      #1;
    end

    // reset mid-broadcast: pulse for tag 30 on the bus, tag 31 held in slot
    drive(mk(1,0,2'b01, 30,'h30, 0,0, 2'b00, 0,0,0));
    @(posedge clk); #1;
    drive(mk(1,0,2'b01, 31,'h31, 0,0, 2'b00, 0,0,0));
    @(posedge clk); #1;
    drive(mk(1,0,2'b00, 0,0, 0,0, 2'b00, 0,0,0));
    #1;
    check("pre-reset cdb_valid",  32'(cdb_v),   32'd1);
    check("pre-reset cdb_rob_id", 32'(cdb_tag), 32'd30);
    rst_n = 1'b0;
    #1;
    check("async reset cdb_valid",  32'(cdb_v),   32'd0);
    check("async reset cdb_rob_id", 32'(cdb_tag), 32'd0);
    check("async reset cdb_value",  cdb_val,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post-reset c%0d cdb_valid", c), 32'(cdb_v), 32'd0);
      check($sformatf("post-reset c%0d req_ready", c), 32'(ready), 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
